ping_pong_ctrl: RTL

//  Stream-side sequencer for ping_pong_buffer, instantiated beside it in the parent.

---
 rtl/ping_pong_ctrl_pkg.sv | 10 +
 rtl/ping_pong_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/ping_pong_ctrl_pkg.sv
// Shared types for the ping-pong buffer stream sequencer.
// Write-side fill state used by ping_pong_ctrl.
package ping_pong_ctrl_pkg;

  typedef enum logic {
    WR_OPEN   = 1'b0,
    WR_CLOSED = 1'b1
  } wr_state_e;

endpackage

// File: rtl/ping_pong_ctrl.sv
// Stream-side sequencer for ping_pong_buffer: fills the write half from a
// valid/ready input stream and drains the read half to a valid/ready output.
//
// Ports:
//   clk, rst              clock, async active-high reset
//   in_data/valid/last    input stream; in_ready = write half open
//   out_data/valid/last   output stream (out_data wired from doutb)
//   out_ready             downstream accept
//   half_swap             1-cycle pulse when ping_pong toggles
//   addra/dina/ena/wea    buffer write port
//   addrb/enb/doutb       buffer read port (1-cycle read latency)
//   ping_pong             half select: 0 = read half 0 / write half 1
module ping_pong_ctrl
  import ping_pong_ctrl_pkg::*;
#(
  parameter  int BIT_LENGTH = 64,
  parameter  int DEPTH      = 16,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BIT_LENGTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [BIT_LENGTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  half_swap,
  output logic [AW-1:0]         addra,
  output logic [BIT_LENGTH-1:0] dina,
  output logic                  ena,
  output logic                  wea,
  output logic [AW-1:0]         addrb,
  output logic                  enb,
  input  logic [BIT_LENGTH-1:0] doutb,
  output logic                  ping_pong
);

  localparam logic [AW:0] ONE  = (AW+1)'(1);
  localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);

  wr_state_e   wr_state;
  wr_state_e   wr_state_nxt;
  logic [AW:0] wr_cnt;
  logic [AW:0] wr_len;
  logic [AW:0] rd_rem;
  logic [AW-1:0] rd_addr;

  logic wr_fire;
  logic wr_close;
  logic rd_idle;
  logic swap;

  assign rd_idle  = (rd_rem == '0);
  assign in_ready = (wr_state == WR_OPEN);
  assign wr_fire  = in_valid & in_ready;
  assign wr_close = wr_fire
                  & (in_last | (wr_cnt == LAST));

  // Swap only once the write half is sealed
  // and every read of the old half issued.
  assign swap = (wr_state == WR_CLOSED)
              & rd_idle;

  assign enb = ~rd_idle
             & (~out_valid | out_ready);

  assign addra    = wr_cnt[AW-1:0];
  assign dina     = in_data;
  assign ena      = wr_fire;
  assign wea      = wr_fire;
  assign addrb    = rd_addr;
  assign out_data = doutb;

  always_comb begin
    wr_state_nxt = wr_state;
    unique case (wr_state)
      WR_OPEN: begin
        if (wr_close)
          wr_state_nxt = WR_CLOSED;
      end
      WR_CLOSED: begin
        if (rd_idle)
          wr_state_nxt = WR_OPEN;
      end
      default: wr_state_nxt = WR_OPEN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wr_state <= WR_OPEN;
    else
      wr_state <= wr_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt <= '0;
      wr_len <= '0;
    end else begin
      if (swap)
        wr_cnt <= '0;
      else if (wr_fire)
        wr_cnt <= wr_cnt + ONE;
      if (wr_close)
        wr_len <= wr_cnt + ONE;
    end
  end

  // swap and enb are exclusive: swap needs
  // rd_rem==0, enb needs rd_rem!=0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ping_pong <= 1'b0;
      half_swap <= 1'b0;
      rd_rem    <= '0;
      rd_addr   <= '0;
      out_last  <= 1'b0;
    end else begin
      half_swap <= swap;
      if (swap) begin
        ping_pong <= ~ping_pong;
        rd_rem    <= wr_len;
        rd_addr   <= '0;
      end else if (enb) begin
        rd_addr  <= rd_addr + 1'b1;
        rd_rem   <= rd_rem - ONE;
        out_last <= (rd_rem == ONE);
      end
    end
  end

  // doutb holds while enb=0, so a stalled
  // word stays on out_data untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      out_valid <= 1'b0;
    else
      out_valid <= enb
                 | (out_valid & ~out_ready);
  end

endmodule
